// File: rtl/fewcore_pkg.sv
// Shared definitions for the fewcore memory path: load/store size codes
// (funct3) and the memory port arbiter state encoding.
package fewcore_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Unused funct3 codes are treated as word accesses.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_B, SZ_BU: mis = 1'b0;
      SZ_H, SZ_HU: mis = off[0];
      SZ_W:        mis = (off != 2'b00);
      default:     mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the load/store unit and the 32-bit memory word.
// Lane 3 ([31:24]) is byte offset 0, so loads shift left by the byte offset.
module mem_lane_align
  import fewcore_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] aligned_rdata,
  output logic        misaligned
);

  // Byte enables and replicated store data for the access size
  always_comb begin
    be         = 4'b1111;
    lane_wdata = wdata;
    case (size)
      SZ_B, SZ_BU: begin
        be         = 4'b1000 >> off;
        lane_wdata = {4{wdata[7:0]}};
      end
      SZ_H, SZ_HU: begin
        be         = 4'b1100 >> off;
        lane_wdata = {2{wdata[15:0]}};
      end
      SZ_W: begin
        be         = 4'b1111;
        lane_wdata = wdata;
      end
      default: begin
        be         = 4'b1111;
        lane_wdata = wdata;
      end
    endcase
  end

  assign misaligned    = is_misaligned(size, off);
  assign aligned_rdata = rdata << {off, 3'b000};

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction at a time, with a starvation guard that eventually favours fetch.
module mem_port_arbiter
  import fewcore_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_done,
  output logic [31:0]     if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [2:0]      ls_size,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [31:0]     ls_wdata,
  output logic            ls_done,
  output logic [31:0]     ls_rdata,
  output logic            ls_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [31:0]     mem_wdata,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  arb_state_e      state_r, state_nxt_s;
  logic [CW-1:0]   starve_cnt_r, starve_nxt_s;
  logic [2:0]      size_r, size_nxt_s;
  logic [1:0]      off_r, off_nxt_s;
  logic            mem_req_r, mem_req_nxt_s;
  logic            mem_we_r, mem_we_nxt_s;
  logic [XLEN-1:0] mem_addr_r, mem_addr_nxt_s;
  logic [3:0]      mem_be_r, mem_be_nxt_s;
  logic [31:0]     mem_wdata_r, mem_wdata_nxt_s;
  logic            if_done_r, if_done_nxt_s;
  logic [31:0]     if_rdata_r, if_rdata_nxt_s;
  logic            ls_done_r, ls_done_nxt_s;
  logic [31:0]     ls_rdata_r, ls_rdata_nxt_s;
  logic            ls_err_r, ls_err_nxt_s;

  logic            grant_ls_s;
  logic            grant_if_s;
  logic [2:0]      align_size_s;
  logic [1:0]      align_off_s;
  logic [3:0]      be_s;
  logic [31:0]     lane_wdata_s;
  logic [31:0]     aligned_rdata_s;
  logic            misaligned_s;
  logic            unused_addr_bits_s;

  assign unused_addr_bits_s = ^if_addr[1:0];

  // Live request fields drive alignment at grant; the latched ones at data capture.
  assign align_size_s = (state_r == IDLE) ? ls_size : size_r;
  assign align_off_s  = (state_r == IDLE) ? ls_addr[1:0] : off_r;

  mem_lane_align u_align (
    .size          (align_size_s),
    .off           (align_off_s),
    .wdata         (ls_wdata),
    .rdata         (mem_rdata),
    .be            (be_s),
    .lane_wdata    (lane_wdata_s),
    .aligned_rdata (aligned_rdata_s),
    .misaligned    (misaligned_s)
  );

  assign grant_ls_s = ls_req & (~if_req | (starve_cnt_r != STARVE_LIM));
  assign grant_if_s = if_req & ~grant_ls_s;

  // Next-state, arbitration and next values of every registered output
  always_comb begin
    state_nxt_s     = state_r;
    starve_nxt_s    = starve_cnt_r;
    size_nxt_s      = size_r;
    off_nxt_s       = off_r;
    mem_req_nxt_s   = mem_req_r;
    mem_we_nxt_s    = mem_we_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_be_nxt_s    = mem_be_r;
    mem_wdata_nxt_s = mem_wdata_r;
    if_done_nxt_s   = 1'b0;
    if_rdata_nxt_s  = if_rdata_r;
    ls_done_nxt_s   = 1'b0;
    ls_rdata_nxt_s  = ls_rdata_r;
    ls_err_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_ls_s) begin
          if (if_req && (starve_cnt_r != STARVE_LIM)) begin
            starve_nxt_s = starve_cnt_r + CW'(1);
          end else begin
            starve_nxt_s = starve_cnt_r;
          end
          size_nxt_s = ls_size;
          off_nxt_s  = ls_addr[1:0];
          if (misaligned_s) begin
            state_nxt_s    = RESP;
            ls_done_nxt_s  = 1'b1;
            ls_err_nxt_s   = 1'b1;
            ls_rdata_nxt_s = 32'h0000_0000;
          end else begin
            state_nxt_s     = DATA;
            mem_req_nxt_s   = 1'b1;
            mem_we_nxt_s    = ls_we;
            mem_addr_nxt_s  = {ls_addr[XLEN-1:2], 2'b00};
            mem_be_nxt_s    = ls_we ? be_s : 4'b1111;
            mem_wdata_nxt_s = ls_we ? lane_wdata_s : 32'h0000_0000;
          end
        end else if (grant_if_s) begin
          starve_nxt_s    = {CW{1'b0}};
          state_nxt_s     = FETCH;
          mem_req_nxt_s   = 1'b1;
          mem_we_nxt_s    = 1'b0;
          mem_addr_nxt_s  = {if_addr[XLEN-1:2], 2'b00};
          mem_be_nxt_s    = 4'b1111;
          mem_wdata_nxt_s = 32'h0000_0000;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH, DATA: begin
        if (mem_ack) begin
          state_nxt_s     = RESP;
          mem_req_nxt_s   = 1'b0;
          mem_we_nxt_s    = 1'b0;
          mem_addr_nxt_s  = {XLEN{1'b0}};
          mem_be_nxt_s    = 4'b0000;
          mem_wdata_nxt_s = 32'h0000_0000;
          if (state_r == FETCH) begin
            if_done_nxt_s  = 1'b1;
            if_rdata_nxt_s = mem_rdata;
          end else begin
            ls_done_nxt_s  = 1'b1;
            ls_rdata_nxt_s = mem_we_r ? 32'h0000_0000 : aligned_rdata_s;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      RESP: begin
        // Requests are not sampled here, so a still-held request is not reissued.
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      starve_cnt_r <= {CW{1'b0}};
      size_r       <= 3'b000;
      off_r        <= 2'b00;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {XLEN{1'b0}};
      mem_be_r     <= 4'b0000;
      mem_wdata_r  <= 32'h0000_0000;
      if_done_r    <= 1'b0;
      if_rdata_r   <= 32'h0000_0000;
      ls_done_r    <= 1'b0;
      ls_rdata_r   <= 32'h0000_0000;
      ls_err_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_nxt_s;
      size_r       <= size_nxt_s;
      off_r        <= off_nxt_s;
      mem_req_r    <= mem_req_nxt_s;
      mem_we_r     <= mem_we_nxt_s;
      mem_addr_r   <= mem_addr_nxt_s;
      mem_be_r     <= mem_be_nxt_s;
      mem_wdata_r  <= mem_wdata_nxt_s;
      if_done_r    <= if_done_nxt_s;
      if_rdata_r   <= if_rdata_nxt_s;
      ls_done_r    <= ls_done_nxt_s;
      ls_rdata_r   <= ls_rdata_nxt_s;
      ls_err_r     <= ls_err_nxt_s;
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_be    = mem_be_r;
  assign mem_wdata = mem_wdata_r;
  assign if_done   = if_done_r;
  assign if_rdata  = if_rdata_r;
  assign ls_done   = ls_done_r;
  assign ls_rdata  = ls_rdata_r;
  assign ls_err    = ls_err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester tasks push expectations,
// a memory responder checks the mem_* side, a done monitor checks responses.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req, ls_req, ls_we, mem_ack;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [2:0]  ls_size;
  logic        if_done, ls_done, ls_err, mem_req, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
  } ls_exp_t;

  logic [31:0] if_exp_q[$];
  ls_exp_t     ls_exp_q[$];
  logic [7:0]  grant_log[$];

  logic        if_mem_pend = 1'b0;
  logic [31:0] if_mem_addr = 32'h0;
  logic        ls_mem_pend = 1'b0;
  logic [31:0] ls_mem_addr = 32'h0;
  logic        ls_mem_we = 1'b0;
  logic [3:0]  ls_mem_be = 4'h0;
  logic [31:0] ls_mem_wdata = 32'h0;
  int          force_wait = -1;
  logic [31:0] mem_model [0:255];

  mem_port_arbiter #(.XLEN(32), .STARVE_MAX(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory: checks each new request against the pending expectation, then acks
  initial begin
    int wl;
    wl = -1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        wl = -1;
      end else if (mem_req) begin
        if (wl < 0) begin
          if (mem_addr[9] == 1'b0) begin
            chk("if_mem_pending", 32'(if_mem_pend), 32'd1);
            chk("if_mem_addr", mem_addr, if_mem_addr);
            chk("if_mem_we", 32'(mem_we), 32'd0);
            chk("if_mem_be", 32'(mem_be), 32'hF);
            if_mem_pend = 1'b0;
          end else begin
            chk("ls_mem_pending", 32'(ls_mem_pend), 32'd1);
            chk("ls_mem_addr", mem_addr, ls_mem_addr);
            chk("ls_mem_we", 32'(mem_we), 32'(ls_mem_we));
            chk("ls_mem_be", 32'(mem_be), 32'(ls_mem_be));
            if (ls_mem_we) chk("ls_mem_wdata", mem_wdata, ls_mem_wdata);
            ls_mem_pend = 1'b0;
          end
          wl = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
        end
        if (wl == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mem_model[mem_addr[9:2]];
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) mem_model[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          end
          wl = -1;
        end else begin
          wl--;
        end
      end else begin
        wl = -1;
      end
    end
  end

  // Done monitor: pops the matching scoreboard entry whenever a done pulse is seen
  always @(negedge clk) begin
    logic [31:0] e_if;
    ls_exp_t     e_ls;
    if (if_done) begin
      if (if_exp_q.size() == 0) begin
        chk("if_done_unexpected", 32'(if_done), 32'd0);
      end else begin
        e_if = if_exp_q.pop_front();
        chk("if_rdata", if_rdata, e_if);
      end
      grant_log.push_back(8'h49);
    end
    if (ls_done) begin
      if (ls_exp_q.size() == 0) begin
        chk("ls_done_unexpected", 32'(ls_done), 32'd0);
      end else begin
        e_ls = ls_exp_q.pop_front();
        chk("ls_err", 32'(ls_err), 32'(e_ls.err));
        if (e_ls.chk_rdata) chk("ls_rdata", ls_rdata, e_ls.rdata);
      end
      grant_log.push_back(8'h4C);
    end
  end

  task automatic run_if(input logic [31:0] addr, output int cyc);
    bit got;
    if_addr = addr;
    if_mem_addr = {addr[31:2], 2'b00};
    if_mem_pend = 1'b1;
    if_exp_q.push_back(mem_model[addr[9:2]]);
    if_req = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (if_done) got = 1'b1;
    end
    if (!got) chk("if_done_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  // Expected result from natural-alignment rules: size in bytes, offset from the top lane.
  task automatic run_ls(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, output int cyc);
    int          nb;
    logic [1:0]  off;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] lw;
    ls_exp_t     e;
    bit          got;
    off = addr[1:0];
    nb = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
    mis = (int'(off) % nb) != 0;
    be = 4'h0;
    if (!mis) for (int k = 0; k < nb; k++) be[3 - (int'(off) + k)] = 1'b1;
    for (int k = 0; k < 4; k++) lw[31 - 8*k -: 8] = wd[8*((3 - k) % nb) +: 8];
    e.err = mis;
    e.chk_rdata = !we || mis;
    e.rdata = mis ? 32'h0 : (mem_model[addr[9:2]] << (8 * int'(off)));
    if (!mis) begin
      ls_mem_addr = {addr[31:2], 2'b00};
      ls_mem_we = we;
      ls_mem_be = we ? be : 4'hF;
      ls_mem_wdata = lw;
      ls_mem_pend = 1'b1;
    end
    ls_exp_q.push_back(e);
    ls_we = we; ls_size = sz; ls_addr = addr; ls_wdata = wd;
    ls_req = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ls_done) got = 1'b1;
    end
    if (!got) chk("ls_done_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    ls_req = 1'b0;
  endtask

  task automatic rand_ls(output int cyc);
    logic [2:0] szs [5];
    szs = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    run_ls(1'($urandom_range(0, 1)), szs[$urandom_range(0, 4)],
           32'h200 + $urandom_range(0, 32'h1FF), $urandom, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [7:0] exp_g [6];
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 3'b000; ls_addr = 32'h0; ls_wdata = 32'h0;
    for (int i = 0; i < 256; i++) mem_model[i] = $urandom;
    mem_model[32'h104 >> 2] = 32'hDEADBEEF;
    mem_model[32'h200 >> 2] = 32'h112233F4;

    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_ls_done", 32'(ls_done), 32'd0);
    chk("rst_ls_err", 32'(ls_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    force_wait = 2;
    run_if(32'h104, cyc);
    chk("fetch_2wait_latency", 32'(cyc), 32'd5);
    force_wait = 0;
    run_if(32'h107, cyc);
    chk("fetch_min_latency", 32'(cyc), 32'd3);
    run_ls(1'b0, 3'b000, 32'h203, 32'h0, cyc);
    chk("lb_latency", 32'(cyc), 32'd3);
    run_ls(1'b1, 3'b001, 32'h302, 32'h0000ABCD, cyc);
    run_ls(1'b0, 3'b101, 32'h302, 32'h0, cyc);
    run_ls(1'b0, 3'b010, 32'h401, 32'h0, cyc);
    chk("misaligned_latency", 32'(cyc), 32'd2);
    run_ls(1'b1, 3'b001, 32'h303, 32'h1234, cyc);
    chk("misaligned_sh_latency", 32'(cyc), 32'd2);

    // Reset while a fetch is waiting with mem_ack already raised
    force_wait = 1;
    if_addr = 32'h108;
    if_mem_addr = 32'h108;
    if_mem_pend = 1'b1;
    if_req = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_async_mem_req", 32'(mem_req), 32'd0);
    chk("rst_async_mem_addr", mem_addr, 32'd0);
    if_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_done", 32'({if_done, ls_done}), 32'd0);
    end
    @(posedge clk); #1;
    force_wait = 0;
    run_if(32'h10C, cyc);
    chk("post_rst_fetch_latency", 32'(cyc), 32'd3);

    // Starvation: both requesters continuously busy
    force_wait = -1;
    grant_log.delete();
    fork
      begin
        int c;
        for (int i = 0; i < 2; i++) run_if(32'($urandom_range(0, 32'h1FF)), c);
      end
      begin
        int c;
        for (int i = 0; i < 4; i++) run_ls(1'b0, 3'b010, 32'h200 + 32'($urandom_range(0, 127)) * 4, 32'h0, c);
      end
    join
    begin
      int li, ii, s;
      li = 4; ii = 2; s = 0;
      for (int k = 0; k < 6; k++) begin
        if (li > 0 && (ii == 0 || s < 2)) begin
          exp_g[k] = 8'h4C;
          if (ii > 0 && s < 2) s++;
          li--;
        end else begin
          exp_g[k] = 8'h49;
          s = 0;
          ii--;
        end
      end
    end
    chk("grant_log_len", 32'(grant_log.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("grant_order_%0d", k),
          32'((k < grant_log.size()) ? grant_log[k] : 8'h3F), 32'(exp_g[k]));

    // Randomised traffic from both requesters
    fork
      begin
        int c, g;
        for (int i = 0; i < 20; i++) begin
          g = $urandom_range(0, 3);
          repeat (g) begin @(posedge clk); #1; end
          run_if(32'($urandom_range(0, 32'h1FF)), c);
        end
      end
      begin
        int c, g;
        for (int i = 0; i < 40; i++) begin
          g = $urandom_range(0, 2);
          repeat (g) begin @(posedge clk); #1; end
          rand_ls(c);
        end
      end
    join

    repeat (4) @(posedge clk);
    chk("if_queue_drained", 32'(if_exp_q.size()), 32'd0);
    chk("ls_queue_drained", 32'(ls_exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
